// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
//   Detects branch/jump mispredicts coming out of the branch execution unit,
//   issues a ROB-tagged flush pulse to the backend and a PC redirect to fetch,
//   then holds a fixed drain window before accepting a new recovery.
//   Only the oldest outstanding mispredict is tracked. Ages are measured
//   relative to the ROB head, so the comparison is safe across ROB wrap.
//   Optional build macro: BRANCH_REDIRECT_STATS_EN adds saturating event
//   counters (stat_branches, stat_mispredicts, stat_dropped).
module branch_redirect_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int ROB_IDX_W    = 5,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  br_valid,
  input  logic [ROB_IDX_W-1:0]  br_rob_idx,
  input  logic [ADDR_WIDTH-1:0] br_pc,
  input  logic                  br_is_jump,
  input  logic [ADDR_WIDTH-1:0] br_target,
  input  logic                  br_pred_taken,
  input  logic [ADDR_WIDTH-1:0] br_pred_target,
  input  logic [ROB_IDX_W-1:0]  rob_head_idx,
  input  logic                  redirect_ready,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush_valid,
  output logic [ROB_IDX_W-1:0]  flush_rob_idx,
`ifdef BRANCH_REDIRECT_STATS_EN
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts,
  output logic [31:0]           stat_dropped,
`endif
  output logic                  recovery_busy
);

  localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     drain_cnt;

  logic                  vld_p0;
  logic                  mispredict_p0;
  logic [ADDR_WIDTH-1:0] correct_pc_p0;
  logic [ROB_IDX_W-1:0]  new_age_p0;
  logic [ROB_IDX_W-1:0]  cur_age_p0;
  logic                  accept_p0;

  // Evaluate the incoming resolution: mispredict detection, correct PC and
  // wrap-safe age comparison against the currently tracked mispredict.
  always_comb begin
    vld_p0        = br_valid;
    mispredict_p0 = vld_p0 &&
                    ((br_pred_taken != br_is_jump) ||
                     (br_is_jump && (br_pred_target != br_target)));
    correct_pc_p0 = br_is_jump ? br_target : (br_pc + ADDR_WIDTH'(4));
    new_age_p0    = br_rob_idx - rob_head_idx;
    cur_age_p0    = flush_rob_idx - rob_head_idx;
    accept_p0     = mispredict_p0 &&
                    ((state == ST_IDLE) || (new_age_p0 < cur_age_p0));
  end

  // ---- stage boundary: resolution evaluation -> recovery sequencer ----

  // Recovery FSM with registered outputs; an accepted (older) mispredict
  // always takes priority over a same-cycle handshake or drain step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      drain_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_valid    <= 1'b0;
      flush_rob_idx  <= '0;
      recovery_busy  <= 1'b0;
    end else begin
      flush_valid <= 1'b0;
      if (accept_p0) begin
        state          <= ST_REDIRECT;
        redirect_valid <= 1'b1;
        redirect_pc    <= correct_pc_p0;
        flush_valid    <= 1'b1;
        flush_rob_idx  <= br_rob_idx;
        recovery_busy  <= 1'b1;
      end else begin
        case (state)
          ST_REDIRECT: begin
            if (redirect_ready) begin
              state          <= ST_DRAIN;
              drain_cnt      <= CNT_W'(DRAIN_CYCLES);
              redirect_valid <= 1'b0;
            end
          end
          ST_DRAIN: begin
            drain_cnt <= drain_cnt - CNT_W'(1);
            if (drain_cnt == CNT_W'(1)) begin
              state         <= ST_IDLE;
              recovery_busy <= 1'b0;
            end
          end
          default: begin
            state          <= ST_IDLE;
            redirect_valid <= 1'b0;
            recovery_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BRANCH_REDIRECT_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  logic drop_p0;

  // A mispredict seen while recovering that is not older gets dropped.
  always_comb begin
    drop_p0 = mispredict_p0 && (state != ST_IDLE) && !accept_p0;
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      stat_dropped     <= '0;
    end else begin
      if (vld_p0)    stat_branches    <= sat_inc(stat_branches);
      if (accept_p0) stat_mispredicts <= sat_inc(stat_mispredicts);
      if (drop_p0)   stat_dropped     <= sat_inc(stat_dropped);
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed testbench for branch_redirect_unit (default parameters,
// DRAIN_CYCLES = 4). Inputs change 1ns after the rising edge and outputs are
// sampled at the same point, so each check sees the state after an edge.
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [4:0]  br_rob_idx;
  logic [31:0] br_pc;
  logic        br_is_jump;
  logic [31:0] br_target;
  logic        br_pred_taken;
  logic [31:0] br_pred_target;
  logic [4:0]  rob_head_idx;
  logic        redirect_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_valid;
  logic [4:0]  flush_rob_idx;
  logic        recovery_busy;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
  logic [31:0] stat_dropped;
`endif

  int vectors = 0;
  int miscompares = 0;

  branch_redirect_unit dut (
    .clk            (clk),
    .rst            (rst),
    .br_valid       (br_valid),
    .br_rob_idx     (br_rob_idx),
    .br_pc          (br_pc),
    .br_is_jump     (br_is_jump),
    .br_target      (br_target),
    .br_pred_taken  (br_pred_taken),
    .br_pred_target (br_pred_target),
    .rob_head_idx   (rob_head_idx),
    .redirect_ready (redirect_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_valid    (flush_valid),
    .flush_rob_idx  (flush_rob_idx),
`ifdef BRANCH_REDIRECT_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
    .stat_dropped     (stat_dropped),
`endif
    .recovery_busy  (recovery_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_br(input logic [4:0] idx, input logic [31:0] pc,
                          input logic jmp, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
    br_valid       = 1'b1;
    br_rob_idx     = idx;
    br_pc          = pc;
    br_is_jump     = jmp;
    br_target      = tgt;
    br_pred_taken  = ptk;
    br_pred_target = ptgt;
  endtask

  task automatic idle_br();
    br_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_br(); redirect_ready = 1'b0; rob_head_idx = '0;
    br_rob_idx = '0; br_pc = '0; br_is_jump = 1'b0; br_target = '0;
    br_pred_taken = 1'b0; br_pred_target = '0;
    tick(); tick();
    vectors++;
    if ({redirect_valid, flush_valid, recovery_busy} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rv/fv/busy=%b required 000",
               {redirect_valid, flush_valid, recovery_busy});
    end
    vectors++;
    if (redirect_pc !== 32'h0 || flush_rob_idx !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_data: got pc=%h idx=%0d required 0/0", redirect_pc, flush_rob_idx);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_correct_pred();
    drive_br(5'd1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h180);
    tick();
    idle_br();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({redirect_valid, flush_valid, recovery_busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL correct_pred[%0d]: got rv/fv/busy=%b required 000", i,
                 {redirect_valid, flush_valid, recovery_busy});
      end
      tick();
    end
  endtask

  task automatic test_direction_mispredict();
    rob_head_idx = 5'd0; redirect_ready = 1'b1;
    drive_br(5'd3, 32'h200, 1'b0, 32'h0, 1'b1, 32'h280);
    tick();
    idle_br();
    vectors++;
    if (redirect_valid !== 1'b1 || flush_valid !== 1'b1 || redirect_pc !== 32'h204 ||
        flush_rob_idx !== 5'd3 || recovery_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL dir_redirect: got rv=%b fv=%b pc=%h idx=%0d busy=%b required 1 1 204 3 1",
               redirect_valid, flush_valid, redirect_pc, flush_rob_idx, recovery_busy);
    end
    // handshake edge, then DRAIN visible for 4 cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (redirect_valid !== 1'b0 || flush_valid !== 1'b0 || recovery_busy !== 1'b1) begin
        miscompares++;
        $display("FAIL dir_drain[%0d]: got rv=%b fv=%b busy=%b required 0 0 1",
                 i, redirect_valid, flush_valid, recovery_busy);
      end
    end
    tick();
    vectors++;
    if (recovery_busy !== 1'b0 || redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dir_idle: got busy=%b rv=%b required 0 0", recovery_busy, redirect_valid);
    end
  endtask

  task automatic test_target_backpressure();
    rob_head_idx = 5'd0; redirect_ready = 1'b0;
    drive_br(5'd7, 32'h380, 1'b1, 32'h400, 1'b1, 32'h300);
    tick();
    idle_br();
    vectors++;
    if (redirect_valid !== 1'b1 || flush_valid !== 1'b1 || redirect_pc !== 32'h400) begin
      miscompares++;
      $display("FAIL tgt_first: got rv=%b fv=%b pc=%h required 1 1 400",
               redirect_valid, flush_valid, redirect_pc);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (redirect_valid !== 1'b1 || flush_valid !== 1'b0 || redirect_pc !== 32'h400 ||
          flush_rob_idx !== 5'd7) begin
        miscompares++;
        $display("FAIL tgt_hold[%0d]: got rv=%b fv=%b pc=%h idx=%0d required 1 0 400 7",
                 i, redirect_valid, flush_valid, redirect_pc, flush_rob_idx);
      end
    end
    redirect_ready = 1'b1;
    tick();
    vectors++;
    if (redirect_valid !== 1'b0 || recovery_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL tgt_accept: got rv=%b busy=%b required 0 1", redirect_valid, recovery_busy);
    end
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (recovery_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tgt_idle: got busy=%b required 0", recovery_busy);
    end
  endtask

  task automatic test_older_wins_wrap();
    rob_head_idx = 5'd30; redirect_ready = 1'b0;
    drive_br(5'd2, 32'h600, 1'b0, 32'h0, 1'b1, 32'h640);
    tick();
    vectors++;
    if (flush_valid !== 1'b1 || flush_rob_idx !== 5'd2 || redirect_pc !== 32'h604) begin
      miscompares++;
      $display("FAIL wrap_first: got fv=%b idx=%0d pc=%h required 1 2 604",
               flush_valid, flush_rob_idx, redirect_pc);
    end
    // older mispredict arrives in the same cycle as the handshake
    redirect_ready = 1'b1;
    drive_br(5'd31, 32'h900, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    idle_br();
    vectors++;
    if (flush_valid !== 1'b1 || flush_rob_idx !== 5'd31 || redirect_pc !== 32'h500 ||
        redirect_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_older: got fv=%b idx=%0d pc=%h rv=%b required 1 31 500 1",
               flush_valid, flush_rob_idx, redirect_pc, redirect_valid);
    end
    tick();
    vectors++;
    if (redirect_valid !== 1'b0 || flush_valid !== 1'b0 || recovery_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_accept: got rv=%b fv=%b busy=%b required 0 0 1",
               redirect_valid, flush_valid, recovery_busy);
    end
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (recovery_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_idle: got busy=%b required 0", recovery_busy);
    end
  endtask

  task automatic test_younger_dropped();
    rob_head_idx = 5'd0; redirect_ready = 1'b1;
    drive_br(5'd5, 32'h700, 1'b0, 32'h0, 1'b1, 32'h740);
    tick();
    idle_br();
    tick(); // handshake -> DRAIN (count 4)
    drive_br(5'd9, 32'h800, 1'b0, 32'h0, 1'b1, 32'h840);
    tick(); // count 3
    idle_br();
    vectors++;
    if (flush_valid !== 1'b0 || redirect_valid !== 1'b0 || flush_rob_idx !== 5'd5 ||
        redirect_pc !== 32'h704) begin
      miscompares++;
      $display("FAIL drop_ignored: got fv=%b rv=%b idx=%0d pc=%h required 0 0 5 704",
               flush_valid, redirect_valid, flush_rob_idx, redirect_pc);
    end
    tick(); tick(); // counts 2, 1
    vectors++;
    if (recovery_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drop_still_drain: got busy=%b required 1", recovery_busy);
    end
    tick();
    vectors++;
    if (recovery_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle: got busy=%b required 0", recovery_busy);
    end
  endtask

  task automatic test_reset_mid_redirect();
    rob_head_idx = 5'd0; redirect_ready = 1'b0;
    drive_br(5'd4, 32'ha00, 1'b1, 32'hb00, 1'b0, 32'h0);
    tick();
    idle_br();
    vectors++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'hb00) begin
      miscompares++;
      $display("FAIL rstmid_pre: got rv=%b pc=%h required 1 b00", redirect_valid, redirect_pc);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({redirect_valid, flush_valid, recovery_busy} !== 3'b000 ||
        redirect_pc !== 32'h0 || flush_rob_idx !== 5'd0) begin
      miscompares++;
      $display("FAIL rstmid_post: got rv/fv/busy=%b pc=%h idx=%0d required 000 0 0",
               {redirect_valid, flush_valid, recovery_busy}, redirect_pc, flush_rob_idx);
    end
    tick();
    vectors++;
    if (recovery_busy !== 1'b0 || redirect_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_idle: got busy=%b rv=%b required 0 0", recovery_busy, redirect_valid);
    end
  endtask

  initial begin
    test_reset();
    test_correct_pred();
    test_direction_mispredict();
    test_target_backpressure();
    test_older_wins_wrap();
    test_younger_dropped();
    test_reset_mid_redirect();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_redirect_unit.md
Name: branch_redirect_unit

Overview:
- Sits directly downstream of the branch execution unit.
- Consumes each resolved branch/jump outcome (actual taken, actual target) plus the prediction carried with the instruction, and detects mispredicts.
- On a mispredict, issues a ROB-tagged flush to the backend and a PC redirect to fetch.
- Sequences a bounded recovery window, tracking only the oldest outstanding mispredict.

Parameters:
- ADDR_WIDTH, 32, PC and target width.
- ROB_IDX_W, 5, ROB index width; the ROB holds 2**ROB_IDX_W entries.
- DRAIN_CYCLES, 4, number of cycles the DRAIN state is held after a redirect handshake; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- br_valid  in  1  resolved branch present this cycle
- br_rob_idx  in  ROB_IDX_W  ROB tag of the branch
- br_pc  in  ADDR_WIDTH  branch instruction address
- br_is_jump  in  1  actual taken (branch taken, JAL or JALR)
- br_target  in  ADDR_WIDTH  actual target when taken
- br_pred_taken  in  1  predicted taken
- br_pred_target  in  ADDR_WIDTH  predicted target
- rob_head_idx  in  ROB_IDX_W  current ROB head (oldest entry), used for age comparison
- redirect_ready  in  1  fetch accepts the redirect
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  ADDR_WIDTH  correct fetch PC
- flush_valid  out  1  one-cycle flush pulse to the backend
- flush_rob_idx  out  ROB_IDX_W  flush all entries younger than this tag
- recovery_busy  out  1  high whenever the state is not IDLE

Behaviour:
- Mispredict condition: (br_pred_taken != br_is_jump) OR (br_is_jump AND br_pred_target != br_target).
- Correct PC: br_is_jump ? br_target : br_pc+4, computed modulo 2**ADDR_WIDTH.
- Age: age(x) = (x - rob_head_idx) mod 2**ROB_IDX_W. A smaller age is older; the comparison is wrap-safe.
- There is no input backpressure. Every br_valid is evaluated in the cycle it arrives.
- Reset: state=IDLE; all outputs 0; the drain counter is 0. Reset mid-recovery aborts the recovery, with IDLE on the next cycle.
- IDLE:
  - Mispredict at cycle N: latch the tag and correct PC, go to REDIRECT.
  - Cycle N+1: redirect_valid=1 and flush_valid=1 (flush_valid is a one-cycle pulse).
  - A correctly predicted branch produces no output.
- REDIRECT:
  - redirect_valid holds, and redirect_pc/flush_rob_idx stay stable, until redirect_ready=1.
  - On the handshake cycle, load the counter with DRAIN_CYCLES and go to DRAIN.
- DRAIN:
  - The counter decrements each cycle; at 1→0, go to IDLE.
  - redirect_valid=0 in this state.
- Mispredict arriving in REDIRECT or DRAIN:
  - If its age < age(latched tag): replace the latched tag and PC, pulse flush_valid on the next cycle, and enter or stay in REDIRECT with redirect_valid=1. An unaccepted older redirect is superseded.
  - Otherwise (younger or equal age): drop it. It has already been squashed.
- Handshake and newer-older mispredict in the same cycle: the new mispredict wins. Next state is REDIRECT with the new PC, and the counter is not loaded.
- Branch arriving in IDLE during the last DRAIN cycle's transition: it is evaluated against IDLE rules in the following cycle only. Inputs are never buffered.

Optional Feature:
- Macro BRANCH_REDIRECT_STATS_EN.
- When defined, adds three outputs:
  - stat_branches [31:0]: counts br_valid.
  - stat_mispredicts [31:0]: counts accepted mispredicts, i.e. those that caused a flush.
  - stat_dropped [31:0]: counts mispredicts dropped as younger.
- All three counters are synchronously reset to 0 and saturate at all-ones.
- When not defined, these ports and counters do not exist and the core behaviour is identical.

Test Plan:
- Correct prediction: br_valid with pc=0x100, is_jump=1, target=0x180, pred_taken=1, pred_target=0x180 -> no redirect_valid or flush_valid; recovery_busy stays 0.
- Direction mispredict: pc=0x200, is_jump=0, pred_taken=1, rob_idx=3, head=0, redirect_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x204, flush_valid=1, flush_rob_idx=3; then 4 cycles of DRAIN; then IDLE.
- Target mispredict with backpressure: is_jump=1, target=0x400, pred_target=0x300, redirect_ready low for 3 cycles -> redirect_valid and redirect_pc=0x400 stable for 4 cycles; flush_valid pulses once.
- Older-wins with ROB wrap: head=30; mispredict tag 2 (age 4), then in REDIRECT a mispredict with tag 31 (age 1), correct PC 0x500 -> second flush pulse with flush_rob_idx=31, redirect_pc=0x500.
- Younger dropped: in DRAIN after a flush of tag 5 (head=0), a mispredict with tag 9 arrives -> no flush or redirect; the DRAIN count continues unchanged.
- Reset mid-REDIRECT: assert rst for 1 cycle while redirect_valid=1 -> all outputs 0 the next cycle; state IDLE.
